// File: rtl/mlp_frame_sched.sv
// Frame scheduler: walks a raster of H_RES x V_RES pixels and issues one pixel job per cycle
// round-robin to N_CORES cores. Define SCHED_PENDING_START_EN to buffer start requests seen mid-frame.
module mlp_frame_sched #(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned H_RES   = 320,
  parameter int unsigned V_RES   = 240
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_start_pulse,
  input  logic                       frame_auto,
  input  logic                       vsync_pulse,
  input  logic [7:0]                 morph_alpha_in,
  input  logic [15:0]                time_val_in,
  input  logic [N_CORES-1:0]         core_done,
  output logic [N_CORES-1:0]         core_start,
  output logic [$clog2(H_RES)-1:0]   pix_x,
  output logic [$clog2(V_RES)-1:0]   pix_y,
  output logic [7:0]                 morph_alpha_frm,
  output logic [15:0]                time_val_frm,
  output logic                       frame_busy,
  output logic                       frame_done
);

  localparam int unsigned XW = $clog2(H_RES);
  localparam int unsigned YW = $clog2(V_RES);
  localparam int unsigned PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [N_CORES-1:0] busy_q, busy_d;
  logic [N_CORES-1:0] core_start_q, core_start_d;
  logic [N_CORES-1:0] issue_vec_c;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]      sel_c;
  logic [XW-1:0]      x_q, x_d, pix_x_q, pix_x_d;
  logic [YW-1:0]      y_q, y_d, pix_y_q, pix_y_d;
  logic [7:0]         alpha_q, alpha_d;
  logic [15:0]        time_q, time_d;
  logic               frame_busy_q, frame_busy_d;
  logic               frame_done_q, frame_done_d;
  logic               start_req_c, launch_c, found_c, issue_c, last_pix_c;

  assign start_req_c = frame_start_pulse | (frame_auto & vsync_pulse);
  assign issue_c     = (state_q == DISPATCH) & found_c;
  assign last_pix_c  = (x_q == XW'(H_RES - 1)) && (y_q == YW'(V_RES - 1));
  assign issue_vec_c = found_c ? (N_CORES'(1) << sel_c) : '0;

`ifdef SCHED_PENDING_START_EN
  logic pend_q, pend_d;

  // A request seen in DONE (or held pending) relaunches straight into DISPATCH
  assign launch_c = (start_req_c & (state_q == IDLE)) |
                    ((pend_q | start_req_c) & (state_q == DONE));

  always_comb begin
    pend_d = pend_q;
    if (launch_c) begin
      pend_d = 1'b0;
    end else if (start_req_c && (state_q != IDLE)) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end
`else
  assign launch_c = start_req_c & (state_q == IDLE);
`endif

  // Round-robin pick: first free core at or above rr_ptr, else lowest free core
  always_comb begin
    found_c = 1'b0;
    sel_c   = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (!found_c && !busy_q[i] && (PW'(i) >= rr_ptr_q)) begin
        found_c = 1'b1;
        sel_c   = PW'(i);
      end
    end
    for (int i = 0; i < N_CORES; i++) begin
      if (!found_c && !busy_q[i]) begin
        found_c = 1'b1;
        sel_c   = PW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (launch_c) state_d = DISPATCH;
      DISPATCH: if (issue_c && last_pix_c) state_d = DRAIN;
      DRAIN:    if (busy_q == '0) state_d = DONE;
      DONE:     state_d = launch_c ? DISPATCH : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs; a same-cycle issue overrides a done on that core
  always_comb begin
    busy_d       = (busy_q & ~core_done) | (issue_c ? issue_vec_c : '0);
    core_start_d = '0;
    rr_ptr_d     = rr_ptr_q;
    x_d          = x_q;
    y_d          = y_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    alpha_d      = alpha_q;
    time_d       = time_q;
    if (launch_c) begin
      alpha_d = morph_alpha_in;
      time_d  = time_val_in;
      x_d     = '0;
      y_d     = '0;
    end
    if (issue_c) begin
      core_start_d = issue_vec_c;
      pix_x_d      = x_q;
      pix_y_d      = y_q;
      rr_ptr_d     = (sel_c == PW'(N_CORES - 1)) ? '0 : sel_c + PW'(1);
      if (x_q == XW'(H_RES - 1)) begin
        x_d = '0;
        y_d = y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
    frame_busy_d = (state_d == DISPATCH) || (state_d == DRAIN);
    frame_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= '0;
      core_start_q <= '0;
      rr_ptr_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      alpha_q      <= '0;
      time_q       <= '0;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      core_start_q <= core_start_d;
      rr_ptr_q     <= rr_ptr_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      alpha_q      <= alpha_d;
      time_q       <= time_d;
      frame_busy_q <= frame_busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign core_start      = core_start_q;
  assign pix_x           = pix_x_q;
  assign pix_y           = pix_y_q;
  assign morph_alpha_frm = alpha_q;
  assign time_val_frm    = time_q;
  assign frame_busy      = frame_busy_q;
  assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_mlp_frame_sched.sv
// Bench for mlp_frame_sched on a 4x2 raster with two cores that acknowledge 3 cycles after start.
module tb_mlp_frame_sched;

  localparam int unsigned N_CORES = 2;
  localparam int unsigned H_RES   = 4;
  localparam int unsigned V_RES   = 2;
  localparam int          NPIX    = H_RES * V_RES;

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] x;
    logic [0:0] y;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               frame_start_pulse;
  logic               frame_auto;
  logic               vsync_pulse;
  logic [7:0]         morph_alpha_in;
  logic [15:0]        time_val_in;
  logic [N_CORES-1:0] core_done = '0;
  logic [N_CORES-1:0] core_start;
  logic [1:0]         pix_x;
  logic [0:0]         pix_y;
  logic [7:0]         morph_alpha_frm;
  logic [15:0]        time_val_frm;
  logic               frame_busy;
  logic               frame_done;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  vec_t tbl [NPIX];
  vec_t iss_q [$];
  vec_t mon_v;
  int   cnt [N_CORES];
  bit [N_CORES-1:0] pend_ack = '0;
  bit               hold     = 1'b0;
  bit [N_CORES-1:0] stray    = '0;

  always #5 clk = ~clk;

  mlp_frame_sched #(.N_CORES(N_CORES), .H_RES(H_RES), .V_RES(V_RES)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .frame_start_pulse (frame_start_pulse),
    .frame_auto        (frame_auto),
    .vsync_pulse       (vsync_pulse),
    .morph_alpha_in    (morph_alpha_in),
    .time_val_in       (time_val_in),
    .core_done         (core_done),
    .core_start        (core_start),
    .pix_x             (pix_x),
    .pix_y             (pix_y),
    .morph_alpha_frm   (morph_alpha_frm),
    .time_val_frm      (time_val_frm),
    .frame_busy        (frame_busy),
    .frame_done        (frame_done)
  );

  // Core model: done pulses 3 cycles after core_start; 'hold' defers them, 'stray' injects extras
  always @(negedge clk) begin
    for (int i = 0; i < N_CORES; i++) begin
      if (core_start[i]) begin
        cnt[i] = 3;
      end else if (cnt[i] > 0) begin
        cnt[i] = cnt[i] - 1;
        if (cnt[i] == 0) pend_ack[i] = 1'b1;
      end
      core_done[i] = (pend_ack[i] & ~hold) | stray[i];
      if (!hold) pend_ack[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && (core_start != '0)) begin
      mon_v.st = core_start;
      mon_v.x  = pix_x;
      mon_v.y  = pix_y;
      iss_q.push_back(mon_v);
    end
    if (rst_n && frame_done) done_cnt = done_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    frame_start_pulse = 1'b1;
    cyc(1);
    frame_start_pulse = 1'b0;
  endtask

  task automatic pulse_vsync();
    vsync_pulse = 1'b1;
    cyc(1);
    vsync_pulse = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok, output int busy_low);
    int c;
    ok = 1'b0;
    busy_low = 0;
    c = 0;
    while (!ok && (c < limit)) begin
      cyc(1);
      c++;
      if (frame_done) ok = 1'b1;
      else if (!frame_busy) busy_low++;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_core_start"}, 32'(core_start), 32'd0);
    check({tag, "_pix_x"},      32'(pix_x), 32'd0);
    check({tag, "_pix_y"},      32'(pix_y), 32'd0);
    check({tag, "_alpha_frm"},  32'(morph_alpha_frm), 32'd0);
    check({tag, "_time_frm"},   32'(time_val_frm), 32'd0);
    check({tag, "_busy"},       32'(frame_busy), 32'd0);
    check({tag, "_done"},       32'(frame_done), 32'd0);
  endtask

  task automatic cmp_frame(input string tag, input int base);
    check({tag, "_issue_count"}, 32'(iss_q.size() - base), 32'(NPIX));
    for (int i = 0; i < NPIX; i++) begin
      if (base + i < iss_q.size())
        check($sformatf("%s_issue%0d", tag, i), 32'(iss_q[base + i]), 32'(tbl[i]));
    end
  endtask

  initial begin
    bit ok;
    int bl;
    int base;
    int dbase;

    // Expected issue order: {one-hot core, x, y}
    tbl[0] = '{st: 2'b01, x: 2'd0, y: 1'b0};
    tbl[1] = '{st: 2'b10, x: 2'd1, y: 1'b0};
    tbl[2] = '{st: 2'b01, x: 2'd2, y: 1'b0};
    tbl[3] = '{st: 2'b10, x: 2'd3, y: 1'b0};
    tbl[4] = '{st: 2'b01, x: 2'd0, y: 1'b1};
    tbl[5] = '{st: 2'b10, x: 2'd1, y: 1'b1};
    tbl[6] = '{st: 2'b01, x: 2'd2, y: 1'b1};
    tbl[7] = '{st: 2'b10, x: 2'd3, y: 1'b1};

    rst_n             = 1'b0;
    frame_start_pulse = 1'b0;
    frame_auto        = 1'b0;
    vsync_pulse       = 1'b0;
    morph_alpha_in    = 8'h5A;
    time_val_in       = 16'h1234;
    cyc(3);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    cyc(2);

    // Basic frame with mid-frame change of the live inputs
    base  = iss_q.size();
    dbase = done_cnt;
    pulse_start();
    check("f1_launch_busy", 32'(frame_busy), 32'd1);
    check("f1_launch_time", 32'(time_val_frm), 32'h1234);
    check("f1_launch_alpha", 32'(morph_alpha_frm), 32'h5A);
    cyc(2);
    time_val_in    = 16'hBEEF;
    morph_alpha_in = 8'hC3;
    wait_done(200, ok, bl);
    check("f1_done_seen", 32'(ok), 32'd1);
    check("f1_busy_low_cycles", 32'(bl), 32'd0);
    check("f1_time_shadow", 32'(time_val_frm), 32'h1234);
    check("f1_alpha_shadow", 32'(morph_alpha_frm), 32'h5A);
    cyc(3);
    check("f1_idle_busy", 32'(frame_busy), 32'd0);
    check("f1_done_pulses", 32'(done_cnt - dbase), 32'd1);
    cmp_frame("f1", base);

    // Stall: acknowledgements withheld for 10 cycles
    hold = 1'b1;
    base = iss_q.size();
    pulse_start();
    cyc(10);
    check("stall_issue_count", 32'(iss_q.size() - base), 32'd2);
    check("stall_core_start", 32'(core_start), 32'd0);
    check("stall_pix_x", 32'(pix_x), 32'd1);
    check("stall_pix_y", 32'(pix_y), 32'd0);
    check("stall_busy", 32'(frame_busy), 32'd1);
    hold = 1'b0;
    wait_done(200, ok, bl);
    check("stall_done_seen", 32'(ok), 32'd1);
    cmp_frame("stall", base);
    check("stall_time_relatched", 32'(time_val_frm), 32'hBEEF);
    check("stall_alpha_relatched", 32'(morph_alpha_frm), 32'hC3);
    cyc(2);

    // vsync launches only with frame_auto
    base = iss_q.size();
    pulse_vsync();
    cyc(3);
    check("vsync_noauto_busy", 32'(frame_busy), 32'd0);
    check("vsync_noauto_issues", 32'(iss_q.size() - base), 32'd0);
    frame_auto = 1'b1;
    pulse_vsync();
    frame_auto = 1'b0;
    check("vsync_auto_busy", 32'(frame_busy), 32'd1);
    wait_done(200, ok, bl);
    check("vsync_auto_done_seen", 32'(ok), 32'd1);
    cmp_frame("vsync_auto", base);
    cyc(2);

    // Start request during DISPATCH
    base  = iss_q.size();
    dbase = done_cnt;
    pulse_start();
    cyc(3);
    pulse_start();
    wait_done(200, ok, bl);
    check("midreq_done_seen", 32'(ok), 32'd1);
    cyc(1);
`ifdef SCHED_PENDING_START_EN
    check("midreq_relaunch_busy", 32'(frame_busy), 32'd1);
    wait_done(200, ok, bl);
    check("midreq_second_done", 32'(ok), 32'd1);
    check("midreq_issue_total", 32'(iss_q.size() - base), 32'(2 * NPIX));
    cyc(3);
    check("midreq_done_pulses", 32'(done_cnt - dbase), 32'd2);
`else
    check("midreq_drop_busy", 32'(frame_busy), 32'd0);
    cyc(5);
    check("midreq_drop_still_idle", 32'(frame_busy), 32'd0);
    check("midreq_issue_total", 32'(iss_q.size() - base), 32'(NPIX));
    check("midreq_done_pulses", 32'(done_cnt - dbase), 32'd1);
`endif
    cyc(2);

    // Reset in the middle of DISPATCH, then stray acknowledgements
    morph_alpha_in = 8'h11;
    time_val_in    = 16'h2222;
    pulse_start();
    cyc(4);
    rst_n = 1'b0;
    cyc(1);
    check_outputs_zero("midrst");
    rst_n = 1'b1;
    base  = iss_q.size();
    dbase = done_cnt;
    stray = 2'b11;
    cyc(1);
    stray = 2'b00;
    cyc(6);
    check("postrst_busy", 32'(frame_busy), 32'd0);
    check("postrst_core_start", 32'(core_start), 32'd0);
    check("postrst_no_issues", 32'(iss_q.size() - base), 32'd0);
    check("postrst_no_done", 32'(done_cnt - dbase), 32'd0);
    check("postrst_time_frm", 32'(time_val_frm), 32'd0);
    pulse_start();
    check("postrst_launch_time", 32'(time_val_frm), 32'h2222);
    wait_done(200, ok, bl);
    check("postrst_done_seen", 32'(ok), 32'd1);
    check("postrst_busy_low_cycles", 32'(bl), 32'd0);
    cmp_frame("postrst", base);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mlp_frame_sched.md
MLP_FRAME_SCHED -- requirements
Module: mlp_frame_sched

Interface
REQ-001 SHALL have parameter N_CORES, default 4: number of mlp_core instances scheduled.
REQ-002 SHALL have parameter H_RES, default 320: pixels per line.
REQ-003 SHALL have parameter V_RES, default 240: lines per frame.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port frame_start_pulse, input, 1: software frame trigger (1-cycle pulse).
REQ-007 SHALL have port frame_auto, input, 1: enables automatic starts on vsync_pulse.
REQ-008 SHALL have port vsync_pulse, input, 1: display frame tick (1-cycle pulse).
REQ-009 SHALL have port morph_alpha_in, input, 8: live blend factor.
REQ-010 SHALL have port time_val_in, input, 16: live frame time.
REQ-011 SHALL have port core_done, input, N_CORES: per-core 1-cycle completion pulse.
REQ-012 SHALL have port core_start, output, N_CORES: one-hot 1-cycle job issue.
REQ-013 SHALL have port pix_x, output, clog2(H_RES): column of issued job, valid with core_start.
REQ-014 SHALL have port pix_y, output, clog2(V_RES): row of issued job, valid with core_start.
REQ-015 SHALL have port morph_alpha_frm, output, 8: shadowed blend factor for current frame.
REQ-016 SHALL have port time_val_frm, output, 16: shadowed time for current frame.
REQ-017 SHALL have port frame_busy, output, 1: high in DISPATCH and DRAIN.
REQ-018 SHALL have port frame_done, output, 1: 1-cycle pulse at frame completion.

Function
REQ-019 FSM states SHALL be IDLE, DISPATCH, DRAIN, DONE, all registered.
REQ-020 Start request SHALL be frame_start_pulse OR (frame_auto AND vsync_pulse).
REQ-021 In IDLE, on a start request: latch morph_alpha_in/time_val_in into the *_frm outputs, clear x/y to 0, go to DISPATCH next cycle.
REQ-022 The *_frm outputs SHALL change only on frame launch; live input changes mid-frame have no effect.
REQ-023 The busy mask SHALL have one bit per core: set on that core's core_start, cleared on its core_done; a core is free when its bit is 0.
REQ-024 In DISPATCH, at most one core per cycle SHALL be issued. Selection is round-robin over free cores, starting the search at rr_ptr. After an issue, rr_ptr becomes issued index+1 mod N_CORES.
REQ-025 core_start, pix_x and pix_y SHALL be registered outputs, asserted in the cycle after the selection decision.
REQ-026 Each issue SHALL advance x. At x==H_RES-1, x wraps to 0 and y increments.
REQ-027 Issuing pixel (H_RES-1, V_RES-1) SHALL move the FSM to DRAIN. Exactly H_RES*V_RES issues occur per frame.
REQ-028 No free core SHALL mean no issue that cycle, with x/y held (stall).
REQ-029 If core_done[i] and a new issue to core i occur in the same cycle, the set wins and the bit stays 1.
REQ-030 A core_done for a core whose busy bit is 0 SHALL be ignored.
REQ-031 In DRAIN, the FSM moves to DONE once the busy mask is all zero.
REQ-032 DONE SHALL last exactly 1 cycle with frame_done=1, then return to IDLE.
REQ-033 Start requests in DISPATCH, DRAIN or DONE SHALL be handled per REQ-038/039.

Reset
REQ-034 On rst_n low, state SHALL be IDLE, and the busy mask, rr_ptr, x, y and pending flag SHALL be 0.
REQ-035 On rst_n low, all outputs SHALL be 0: core_start, pix_x, pix_y, morph_alpha_frm, time_val_frm, frame_busy, frame_done.
REQ-036 Reset mid-frame SHALL abandon the frame immediately. Late core_done pulses after reset are ignored per REQ-030.

Configuration
REQ-037 Macro SCHED_PENDING_START_EN SHALL select start-request buffering.
REQ-038 With SCHED_PENDING_START_EN defined, a start request outside IDLE sets a 1-deep pending flag (further requests are merged). In DONE with pending set, the FSM clears the flag and launches as REQ-021 directly to DISPATCH, bypassing IDLE.
REQ-039 With SCHED_PENDING_START_EN undefined, start requests outside IDLE SHALL be dropped.

Verification
REQ-040 H_RES=4, V_RES=2, N_CORES=2, cores ack 3 cycles after start: pulse frame_start_pulse -> 8 issues in raster order; core index alternates 0,1,0,1...; frame_busy high throughout; one frame_done pulse; then IDLE.
REQ-041 Hold core_done low for 10 cycles -> after 2 issues, core_start stays 0 and x/y hold; releasing core_done resumes issue.
REQ-042 time_val_in=0x1234 at launch, changed to 0xBEEF mid-frame -> time_val_frm stays 0x1234 until the next launch.
REQ-043 frame_auto=0 with vsync_pulse -> no start; frame_auto=1 with vsync_pulse -> frame launches.
REQ-044 frame_start_pulse during DISPATCH -> with the macro, a second frame begins right after frame_done with no IDLE cycle; without it, the FSM returns to IDLE and stays there.
REQ-045 rst_n low mid-DISPATCH, then core_done pulses -> all outputs 0, state IDLE, stray done pulses ignored, next start request behaves normally.
